stt_decoder: RTL



---
 rtl/stt_pkg.sv | 39 +++
 rtl/stt_code_check.sv | 23 ++
 rtl/stt_decoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/stt_pkg.sv
// Shared definitions for the 4-state transition-table code link (encoder and decoder).
// Holds the code geometry, state encoding, decoder FSM states and the transition table.
package stt_pkg;

  localparam int STATE_W    = 2;
  localparam int CODE_W     = 8;
  localparam int NUM_STATES = 4;

  localparam logic [STATE_W-1:0] ST_S0 = 2'd0;
  localparam logic [STATE_W-1:0] ST_S1 = 2'd1;
  localparam logic [STATE_W-1:0] ST_S2 = 2'd2;
  localparam logic [STATE_W-1:0] ST_S3 = 2'd3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } dec_fsm_t;

  // Encoder transition table; the encoder side regenerates state with this same function.
  function automatic logic [STATE_W-1:0] next_state(input logic [STATE_W-1:0] src,
                                                    input logic               in_bit);
    logic [STATE_W-1:0] nxt;
    nxt = ST_S0;
    case ({src, in_bit})
      {ST_S0, 1'b0}: nxt = ST_S2;
      {ST_S0, 1'b1}: nxt = ST_S1;
      {ST_S1, 1'b0}: nxt = ST_S1;
      {ST_S1, 1'b1}: nxt = ST_S2;
      {ST_S2, 1'b0}: nxt = ST_S2;
      {ST_S2, 1'b1}: nxt = ST_S3;
      {ST_S3, 1'b0}: nxt = ST_S0;
      {ST_S3, 1'b1}: nxt = ST_S3;
      default:       nxt = ST_S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/stt_code_check.sv
// Combinational decode of one transition code against the tracked encoder state.
// Zero latency; no flow control, pure function of its inputs.
module stt_code_check
  import stt_pkg::*;
(
  input  logic [CODE_W-1:0]  i_code,
  input  logic [STATE_W-1:0] i_exp_state,
  output logic               o_legal,
  output logic               o_consistent,
  output logic               o_in,
  output logic [STATE_W-1:0] o_nxt
);

  logic [STATE_W-1:0] w_src;

  // Legal codes are 0..7: upper bits must all be zero.
  assign o_legal      = (i_code[CODE_W-1:3] == '0);
  assign w_src        = i_code[2:1];
  assign o_in         = i_code[0];
  assign o_consistent = o_legal && (w_src == i_exp_state);
  assign o_nxt        = next_state(w_src, o_in);

endmodule

// File: rtl/stt_decoder.sv
// Recovers the 1-bit input stream from transition codes, tracking lock and counting errors.
// One-cycle registered response; no backpressure, a code may arrive every cycle.
module stt_decoder
  import stt_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2,
  parameter int ERR_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_code_valid,
  input  logic [CODE_W-1:0]  i_code,
  output logic               o_bit_valid,
  output logic               o_bit_out,
  output logic [STATE_W-1:0] o_exp_state,
  output logic               o_sync,
  output logic               o_err,
  output logic [ERR_W-1:0]   o_err_count
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0] MISS_TGT = 4'(MISS_MAX);

  dec_fsm_t           r_fsm;
  logic [STATE_W-1:0] r_exp_state;
  logic [3:0]         r_run_cnt;
  logic [3:0]         r_miss_cnt;
  logic               r_bit_valid;
  logic               r_bit_out;
  logic               r_sync;
  logic               r_err;
  logic [ERR_W-1:0]   r_err_count;

  logic               w_legal;
  logic               w_consistent;
  logic               w_in;
  logic [STATE_W-1:0] w_nxt;
  logic               w_err;
  logic [3:0]         w_run_inc;
  logic [3:0]         w_miss_inc;

  stt_code_check u_check (
    .i_code       (i_code),
    .i_exp_state  (r_exp_state),
    .o_legal      (w_legal),
    .o_consistent (w_consistent),
    .o_in         (w_in),
    .o_nxt        (w_nxt)
  );

  assign w_run_inc  = r_run_cnt + 4'd1;
  assign w_miss_inc = r_miss_cnt + 4'd1;

  // HUNT only rejects illegal codes; once a run has started every code must also chain.
  always_comb begin
    w_err = 1'b0;
    if (i_code_valid) begin
      if (r_fsm == HUNT) w_err = !w_legal;
      else               w_err = !w_consistent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= HUNT;
      r_exp_state <= '0;
      r_run_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_bit_valid <= 1'b0;
      r_bit_out   <= 1'b0;
      r_sync      <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_bit_valid <= 1'b0;
      r_err       <= w_err;
      if (w_err && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;

      if (i_code_valid) begin
        case (r_fsm)
          HUNT: begin
            if (w_legal) begin
              r_exp_state <= w_nxt;
              r_run_cnt   <= 4'd1;
              if (LOCK_TGT == 4'd1) begin
                r_fsm      <= LOCKED;
                r_sync     <= 1'b1;
                r_miss_cnt <= '0;
              end else begin
                r_fsm <= CHECK;
              end
            end
          end
          CHECK: begin
            if (w_consistent) begin
              r_exp_state <= w_nxt;
              r_run_cnt   <= w_run_inc;
              if (w_run_inc == LOCK_TGT) begin
                r_fsm      <= LOCKED;
                r_sync     <= 1'b1;
                r_miss_cnt <= '0;
              end
            end else begin
              r_fsm     <= HUNT;
              r_run_cnt <= '0;
            end
          end
          LOCKED: begin
            if (w_consistent) begin
              r_bit_valid <= 1'b1;
              r_bit_out   <= w_in;
              r_exp_state <= w_nxt;
              r_miss_cnt  <= '0;
            end else begin
              // A legal but off-chain code resyncs the tracker; garbage leaves it alone.
              if (w_legal) r_exp_state <= w_nxt;
              if (w_miss_inc >= MISS_TGT) begin
                r_fsm      <= HUNT;
                r_sync     <= 1'b0;
                r_miss_cnt <= '0;
                r_run_cnt  <= '0;
              end else begin
                r_miss_cnt <= w_miss_inc;
              end
            end
          end
          default: begin
            r_fsm  <= HUNT;
            r_sync <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_bit_valid = r_bit_valid;
  assign o_bit_out   = r_bit_out;
  assign o_exp_state = r_exp_state;
  assign o_sync      = r_sync;
  assign o_err       = r_err;
  assign o_err_count = r_err_count;

endmodule
